emulador_dht11: RTL and testbench

Synthesizable DHT11 sensor emulator: the responder end of the single-wire DHT11 protocol. It detects the host start pulse on the open-drain bus and answers with the response preamble and a 40-bit frame built from programmable humidity/temperature values. It is used for FPGA-in-the-loop and simulation testing of the DHT11 measurement path, including its retry and timeout handling, through fault-injection inputs.

---
 rtl/emulador_dht11.sv | 267 ++++++++++++++++++++++++++
 tb/tb_emulador_dht11.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emulador_dht11.sv
// -----------------------------------------------------------------------------
// emulador_dht11
//
// Responder side of the single-wire DHT11 protocol. The block waits for the
// host start pulse on the open-drain bus. It then answers with the 80/80 us
// response preamble, followed by a 40-bit frame (humidity, temperature and
// checksum) and a closing low pulse. Two fault-injection inputs let a
// measurement path be tested against a corrupted checksum and against a
// silent sensor.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high
//   dht_bus        open-drain bus; only ever driven to 0 or released (Z)
//   umidade        humidity   {integer byte, decimal byte}, sampled at start
//   temperatura    temperature {integer byte, decimal byte}, sampled at start
//   erro_checksum  sampled at start; inverts the transmitted checksum
//   sem_resposta   sampled at start; accept the start but never answer
//   ocupado        high from start acceptance until the frame is finished
//   enviado        one-cycle pulse when a complete frame has been sent
//   db_estado      current FSM state encoding
// -----------------------------------------------------------------------------
module emulador_dht11 #(
   parameter int CICLOS_US      = 50,
   parameter int T_START_MIN_US = 18000,
   parameter int T_ESPERA_US    = 30
) (
   input  logic        clock,
   input  logic        reset,
   inout  wire         dht_bus,
   input  logic [15:0] umidade,
   input  logic [15:0] temperatura,
   input  logic        erro_checksum,
   input  logic        sem_resposta,
   output logic        ocupado,
   output logic        enviado,
   output logic [3:0]  db_estado
);

   localparam int N_START    = T_START_MIN_US * CICLOS_US;
   localparam int N_ESPERA   = T_ESPERA_US * CICLOS_US;
   localparam int N_RESP     = 80 * CICLOS_US;
   localparam int N_BAIXO    = 50 * CICLOS_US;
   localparam int N_BIT0     = 26 * CICLOS_US;
   localparam int N_BIT1     = 70 * CICLOS_US;
   localparam int N_SILENCIO = (T_ESPERA_US + 160 + 40 * 120) * CICLOS_US;

   // The silent window can outlast the start threshold when the timing
   // parameters are scaled down, so the counter must hold either limit.
   localparam int CNT_MAX = (N_START > N_SILENCIO) ? N_START : N_SILENCIO;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] C_START    = CW'(N_START);
   localparam logic [CW-1:0] L_ESPERA   = CW'(N_ESPERA - 1);
   localparam logic [CW-1:0] L_RESP     = CW'(N_RESP - 1);
   localparam logic [CW-1:0] L_BAIXO    = CW'(N_BAIXO - 1);
   localparam logic [CW-1:0] L_BIT0     = CW'(N_BIT0 - 1);
   localparam logic [CW-1:0] L_BIT1     = CW'(N_BIT1 - 1);
   localparam logic [CW-1:0] L_SILENCIO = CW'(N_SILENCIO - 1);

   typedef enum logic [3:0] {
      OCIOSO     = 4'd0,
      START      = 4'd1,
      ESPERA     = 4'd2,
      RESP_BAIXO = 4'd3,
      RESP_ALTO  = 4'd4,
      BIT_BAIXO  = 4'd5,
      BIT_ALTO   = 4'd6,
      FIM_BAIXO  = 4'd7,
      FIM        = 4'd8,
      SILENCIO   = 4'd9
   } estado_t;

   estado_t        state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [5:0]     bit_q, bit_d;
   logic [39:0]    frame_q, frame_d;
   logic           sem_q, sem_d;
   logic           puxa_q, puxa_d;
   logic           ocupado_q, ocupado_d;
   logic           enviado_q, enviado_d;
   logic [1:0]     sync_q, sync_d;
   logic           bus_s;

   // Start-pulse counter stops at the acceptance threshold so that a bus
   // held low indefinitely cannot wrap around into a false rejection.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= C_START) ? v : v + 1'b1;
   endfunction

   function automatic logic [7:0] checksum(input logic [15:0] h,
                                           input logic [15:0] t,
                                           input logic        err);
      logic [7:0] s;
      s = h[15:8] + h[7:0] + t[15:8] + t[7:0];
      return err ? (s ^ 8'hFF) : s;
   endfunction

   // ---- bus synchronizer ----
   assign sync_d = {sync_q[0], dht_bus};
   assign bus_s  = sync_q[1];

   // ---- next-state logic ----
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      frame_d   = frame_q;
      sem_d     = sem_q;
      ocupado_d = ocupado_q;
      enviado_d = 1'b0;

      case (state_q)
         OCIOSO: begin
            if (!bus_s) begin
               state_d = START;
               // The low sample that triggered the transition is the first
               // counted cycle of the start pulse.
               cnt_d   = CW'(1);
            end
         end

         START: begin
            if (bus_s) begin
               if (cnt_q >= C_START) begin
                  frame_d   = {umidade, temperatura,
                               checksum(umidade, temperatura, erro_checksum)};
                  sem_d     = sem_resposta;
                  ocupado_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ESPERA;
               end else begin
                  state_d   = OCIOSO;
               end
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end

         ESPERA: begin
            if (cnt_q == L_ESPERA) begin
               cnt_d   = '0;
               state_d = sem_q ? SILENCIO : RESP_BAIXO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         SILENCIO: begin
            if (cnt_q == L_SILENCIO) begin
               cnt_d     = '0;
               ocupado_d = 1'b0;
               state_d   = OCIOSO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RESP_BAIXO: begin
            if (cnt_q == L_RESP) begin
               cnt_d   = '0;
               state_d = RESP_ALTO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RESP_ALTO: begin
            if (cnt_q == L_RESP) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = BIT_BAIXO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         BIT_BAIXO: begin
            if (cnt_q == L_BAIXO) begin
               cnt_d   = '0;
               state_d = BIT_ALTO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         BIT_ALTO: begin
            // The frame shifts left, so the bit on the wire is always the MSB.
            if (cnt_q == (frame_q[39] ? L_BIT1 : L_BIT0)) begin
               cnt_d = '0;
               if (bit_q == 6'd39) begin
                  state_d = FIM_BAIXO;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  frame_d = {frame_q[38:0], 1'b0};
                  state_d = BIT_BAIXO;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         FIM_BAIXO: begin
            if (cnt_q == L_BAIXO) begin
               cnt_d     = '0;
               enviado_d = 1'b1;
               ocupado_d = 1'b0;
               state_d   = FIM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         FIM: begin
            // Returning to idle only on a released bus avoids reading our own
            // closing low pulse as a new start request.
            if (bus_s) state_d = OCIOSO;
         end

         default: begin
            cnt_d   = '0;
            state_d = OCIOSO;
         end
      endcase
   end

   // The bus driver follows the current state one clock later, which keeps
   // every phase exactly its nominal length and the bus path registered.
   always_comb begin
      puxa_d = 1'b0;
      case (state_q)
         RESP_BAIXO, BIT_BAIXO, FIM_BAIXO: puxa_d = 1'b1;
         default:                          puxa_d = 1'b0;
      endcase
   end

   // ---- registers ----
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= OCIOSO;
         cnt_q     <= '0;
         bit_q     <= '0;
         sem_q     <= 1'b0;
         puxa_q    <= 1'b0;
         ocupado_q <= 1'b0;
         enviado_q <= 1'b0;
         sync_q    <= 2'b11;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sem_q     <= sem_d;
         puxa_q    <= puxa_d;
         ocupado_q <= ocupado_d;
         enviado_q <= enviado_d;
         sync_q    <= sync_d;
      end
      frame_q <= frame_d;
   end

   // ---- outputs ----
   assign dht_bus   = puxa_q ? 1'b0 : 1'bz;
   assign ocupado   = ocupado_q;
   assign enviado   = enviado_q;
   assign db_estado = state_q;

endmodule

// File: tb/tb_emulador_dht11.sv
// -----------------------------------------------------------------------------
// tb_emulador_dht11
//
// Directed bench for emulador_dht11 with scaled timing (1 cycle per us).
// Expected frames are queued when a start pulse is issued. They are popped and
// compared once the bench-side reader has decoded the frame from the bus.
// -----------------------------------------------------------------------------
module tb_emulador_dht11;

   localparam int CICLOS_US = 1;
   localparam int T_START   = 20;
   localparam int T_ESP     = 30;

   logic        clock = 1'b0;
   logic        reset;
   wire         dht_bus;
   logic        host_low;
   logic [15:0] umidade;
   logic [15:0] temperatura;
   logic        erro_checksum;
   logic        sem_resposta;
   logic        ocupado;
   logic        enviado;
   logic [3:0]  db_estado;

   int          tests = 0;
   int          fails = 0;
   int          env_cnt = 0;
   int          env_bad = 0;
   logic        prev_ocup = 1'b0;
   logic [39:0] exp_q[$];

   always #5 clock = ~clock;

   assign dht_bus = host_low ? 1'b0 : 1'bz;
   pullup (dht_bus);

   emulador_dht11 #(
      .CICLOS_US      (CICLOS_US),
      .T_START_MIN_US (T_START),
      .T_ESPERA_US    (T_ESP)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .dht_bus       (dht_bus),
      .umidade       (umidade),
      .temperatura   (temperatura),
      .erro_checksum (erro_checksum),
      .sem_resposta  (sem_resposta),
      .ocupado       (ocupado),
      .enviado       (enviado),
      .db_estado     (db_estado)
   );

   // enviado must be a single-cycle pulse coinciding with ocupado falling
   always @(negedge clock) begin
      if (enviado === 1'b1) begin
         env_cnt++;
         if (!(prev_ocup === 1'b1 && ocupado === 1'b0)) env_bad++;
      end
      prev_ocup = ocupado;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] frame_of(input logic [15:0] h, input logic [15:0] t,
                                            input logic err);
      logic [7:0] cs;
      cs = h[15:8] + h[7:0] + t[15:8] + t[7:0];
      if (err) cs = cs ^ 8'hFF;
      return {h, t, cs};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic start_pulse(input int n);
      @(negedge clock);
      host_low = 1'b1;
      repeat (n) @(negedge clock);
      host_low = 1'b0;
      @(negedge clock);
   endtask

   task automatic wait_low(input int lim, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (dht_bus === 1'b0) begin
            seen = 1'b1;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic run_len(input logic lvl, input int lim, output int n);
      n = 0;
      while (dht_bus === lvl && n < lim) begin
         n++;
         @(negedge clock);
      end
   endtask

   // Bench-side reader: decodes one frame from the bus by pulse widths.
   task automatic receive_frame(input int abort_bit, input int mutate_bit,
                                output logic [39:0] data, output bit ok, output int bad_w);
      int rl, rh, lo, hi;
      bit seen;
      data  = '0;
      ok    = 1'b0;
      bad_w = 0;
      wait_low(300, seen);
      if (!seen) return;
      run_len(1'b0, 300, rl);
      run_len(1'b1, 300, rh);
      if (rl != 80 * CICLOS_US) bad_w++;
      if (rh != 80 * CICLOS_US) bad_w++;
      for (int i = 0; i < 40; i++) begin
         if (i == abort_bit) return;
         if (i == mutate_bit) umidade = 16'hFFFF;
         run_len(1'b0, 300, lo);
         run_len(1'b1, 300, hi);
         if (lo != 50 * CICLOS_US) bad_w++;
         if (hi == 70 * CICLOS_US) data = {data[38:0], 1'b1};
         else begin
            if (hi != 26 * CICLOS_US) bad_w++;
            data = {data[38:0], 1'b0};
         end
      end
      run_len(1'b0, 300, lo);
      if (lo != 50 * CICLOS_US) bad_w++;
      ok = 1'b1;
   endtask

   initial begin
      logic [39:0] d;
      logic [39:0] e;
      logic [7:0]  sum;
      bit          ok;
      bit          rd_erro;
      int          bw;
      int          lows;
      int          busy;
      int          attempts;
      bit          freed;

      reset         = 1'b1;
      host_low      = 1'b0;
      umidade       = 16'h3C00;
      temperatura   = 16'h1905;
      erro_checksum = 1'b0;
      sem_resposta  = 1'b0;
      idle(3);
      reset = 1'b0;
      idle(3);
      check("rst_estado", db_estado, 4'd0);
      check("rst_ocupado", ocupado, 1'b0);
      check("rst_enviado", enviado, 1'b0);
      check("rst_bus", dht_bus, 1'b1);

      // Test 1: nominal frame
      exp_q.push_back(frame_of(16'h3C00, 16'h1905, 1'b0));
      start_pulse(25);
      receive_frame(-1, -1, d, ok, bw);
      check("t1_ok", ok, 1'b1);
      check("t1_widths", bw, 0);
      e = exp_q.pop_front();
      check("t1_frame", d, e);
      check("t1_cs", d[7:0], 8'h5A);
      idle(20);
      check("t1_enviado_cnt", env_cnt, 1);
      check("t1_ocupado_end", ocupado, 1'b0);

      // Test 2: runt start pulse ignored, threshold pulse accepted
      start_pulse(19);
      lows = 0;
      busy = 0;
      for (int i = 0; i < 100; i++) begin
         if (dht_bus === 1'b0) lows++;
         if (ocupado === 1'b1) busy++;
         @(negedge clock);
      end
      check("t2_runt_bus", lows, 0);
      check("t2_runt_ocupado", busy, 0);
      check("t2_runt_estado", db_estado, 4'd0);
      exp_q.push_back(frame_of(16'h3C00, 16'h1905, 1'b0));
      start_pulse(20);
      receive_frame(-1, -1, d, ok, bw);
      check("t2_ok", ok, 1'b1);
      e = exp_q.pop_front();
      check("t2_frame", d, e);
      idle(20);
      check("t2_enviado_cnt", env_cnt, 2);

      // Test 3: corrupted checksum, reader retries then gives up
      erro_checksum = 1'b1;
      attempts = 0;
      rd_erro  = 1'b1;
      for (int a = 0; a < 3; a++) begin
         exp_q.push_back(frame_of(16'h3C00, 16'h1905, 1'b1));
         start_pulse(25);
         receive_frame(-1, -1, d, ok, bw);
         attempts++;
         e = exp_q.pop_front();
         check("t3_frame", d, e);
         check("t3_cs", d[7:0], 8'hA5);
         idle(20);
         sum = d[39:32] + d[31:24] + d[23:16] + d[15:8];
         if (ok && sum == d[7:0]) begin
            rd_erro = 1'b0;
            break;
         end
      end
      erro_checksum = 1'b0;
      check("t3_attempts", attempts, 3);
      check("t3_reader_erro", rd_erro, 1'b1);
      check("t3_enviado_cnt", env_cnt, 5);

      // Test 4: silent sensor
      sem_resposta = 1'b1;
      start_pulse(25);
      receive_frame(-1, -1, d, ok, bw);
      check("t4_reader_timeout", ok, 1'b0);
      check("t4_estado", db_estado, 4'd9);
      lows = 0;
      busy = 0;
      for (int i = 0; i < 4500; i++) begin
         if (dht_bus === 1'b0) lows++;
         if (ocupado !== 1'b1) busy++;
         @(negedge clock);
      end
      sem_resposta = 1'b0;
      check("t4_bus_low", lows, 0);
      check("t4_ocupado_drop", busy, 0);
      freed = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (ocupado === 1'b0) begin
            freed = 1'b1;
            break;
         end
         @(negedge clock);
      end
      check("t4_ocupado_release", freed, 1'b1);
      idle(10);
      check("t4_enviado_cnt", env_cnt, 5);
      check("t4_estado_end", db_estado, 4'd0);

      // Test 5: reset during bit 17
      start_pulse(25);
      receive_frame(17, -1, d, ok, bw);
      check("t5_low_before_rst", dht_bus, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      check("t5_bus_rst", dht_bus, 1'b1);
      check("t5_ocupado_rst", ocupado, 1'b0);
      check("t5_enviado_rst", enviado, 1'b0);
      check("t5_estado_rst", db_estado, 4'd0);
      reset = 1'b0;
      idle(5);
      check("t5_enviado_cnt", env_cnt, 5);
      exp_q.push_back(frame_of(16'h3C00, 16'h1905, 1'b0));
      start_pulse(25);
      receive_frame(-1, -1, d, ok, bw);
      check("t5_ok", ok, 1'b1);
      check("t5_widths", bw, 0);
      e = exp_q.pop_front();
      check("t5_frame", d, e);
      idle(20);
      check("t5_enviado_after", env_cnt, 6);

      // Test 6: input change mid-frame does not alter the frame in flight
      exp_q.push_back(frame_of(16'h3C00, 16'h1905, 1'b0));
      start_pulse(25);
      receive_frame(-1, 5, d, ok, bw);
      check("t6_ok", ok, 1'b1);
      e = exp_q.pop_front();
      check("t6_frame", d, e);
      check("t6_frame_lit", d, 40'h3C0019055A);
      umidade = 16'h3C00;
      idle(20);
      check("t6_enviado_cnt", env_cnt, 7);

      check("enviado_pulse_shape", env_bad, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
